seq_divider: RTL

- Multi-cycle unsigned restoring divider for the datapath. It is the inverse-direction companion of the combinational adder: it produces quotient and remainder by iterative shift-and-subtract.
- Operands are captured on a Start strobe. One quotient bit is resolved per clock. Completion is signalled with a one-cycle Done pulse.
- Sits beside the adder in the ALU. The controller issues Start and waits for Done.

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_sub_stage.sv | 16 +
 rtl/seq_divider.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encodings and default width for the sequential divider
package seq_divider_pkg;

  localparam int WITH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_sub_stage.sv
// rtl/seq_divider_sub_stage.sv - combinational WITH+1-bit subtractor with borrow out
module seq_divider_sub_stage #(
  parameter int WITH = 8
) (
  input  logic [WITH:0] a,
  input  logic [WITH:0] b,
  output logic [WITH:0] diff,
  output logic          borrow
);

  // The extra top bit of the widened difference is the borrow.
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WITH = WITH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [WITH-1:0] OperA,
  input  logic [WITH-1:0] OperB,
  output logic            Busy,
  output logic            Done,
  output logic [WITH-1:0] Quotient,
  output logic [WITH-1:0] Remainder,
  output logic            DivByZero
);

  localparam int CNT_W = $clog2(WITH + 1);

  state_t state, next_state;

  logic [WITH-1:0]  dvd;
  logic [WITH-1:0]  dvs;
  logic [WITH:0]    part_rem;
  logic [CNT_W-1:0] cnt;

  logic [WITH:0] rem_shift;
  logic [WITH:0] diff;
  logic          borrow;
  logic [WITH:0] rem_next;

  logic accept;
  logic opb_zero;
  logic last_iter;

  assign opb_zero  = (OperB == '0);
  assign rem_shift = (part_rem << 1) | {{WITH{1'b0}}, dvd[WITH-1]};
  assign rem_next  = borrow ? rem_shift : diff;

  seq_divider_sub_stage #(.WITH(WITH)) u_sub (
    .a      (rem_shift),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE accepts a new request just like IDLE so operations can run back to back.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE, DONE: begin
        next_state = IDLE;
        if (Start) begin
          accept     = 1'b1;
          next_state = opb_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WITH - 1)) begin
          last_iter  = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  // The dividend register doubles as the quotient register: MSBs shift out, quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd       <= '0;
      dvs       <= '0;
      part_rem  <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      if (accept) begin
        dvd      <= OperA;
        dvs      <= OperB;
        part_rem <= '0;
        cnt      <= '0;
      end else if (state == RUN) begin
        dvd      <= {dvd[WITH-2:0], ~borrow};
        part_rem <= rem_next;
        cnt      <= cnt + CNT_W'(1);
      end

      if (accept && opb_zero) begin
        Quotient  <= '1;
        Remainder <= OperA;
        DivByZero <= 1'b1;
      end else if (last_iter) begin
        Quotient  <= {dvd[WITH-2:0], ~borrow};
        Remainder <= rem_next[WITH-1:0];
        DivByZero <= 1'b0;
      end
    end
  end

endmodule
